// File: rtl/uart_rx_ctrl_if.sv
// Host-side word stream of the UART receive controller.
// master drives o_data/o_data_valid, slave returns i_data_ready.
interface uart_rx_ctrl_if;
    logic [8:0] o_data;
    logic       o_data_valid;
    logic       i_data_ready;

    modport master (
        output o_data,
        output o_data_valid,
        input  i_data_ready
    );

    modport slave (
        input  o_data,
        input  o_data_valid,
        output i_data_ready
    );
endinterface

// File: rtl/uart_rx_ctrl.sv
// Controller between uart_rx and the host. It sequences frame-format
// updates so the store strobe only fires when the receiver is idle and
// the line is high. Received words go through a first-word-fall-through
// FIFO to the host stream. It also keeps overflow and error statistics.
// Ports: i_clk/i_rst_n; i_cfg_* requests with o_cfg_busy/o_cfg_active;
// o_rx_config and i_rx_* to the receiver; host stream via `host`;
// o_fifo_count, o_overflow, o_err_count; i_clear_status, i_flush.
module uart_rx_ctrl #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic [3:0]    i_cfg_word_size,
    input  logic          i_cfg_parity_en,
    input  logic          i_cfg_two_stop,
    input  logic          i_cfg_apply,
    output logic          o_cfg_busy,
    output logic [5:0]    o_cfg_active,
    output logic [6:0]    o_rx_config,
    input  logic [8:0]    i_rx_parallel,
    input  logic          i_rx_valid,
    input  logic          i_rx_ready,
    input  logic          i_rx_error,
    input  logic          i_rx_line,
    uart_rx_ctrl_if.master host,
    output logic [AW:0]   o_fifo_count,
    output logic          o_overflow,
    output logic [7:0]    o_err_count,
    input  logic          i_clear_status,
    input  logic          i_flush
);

    typedef enum logic {
        RUN,
        CFG_PEND
    } state_e;

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [5:0]  CFG_RST  = 6'b00_1000;

    state_e        state_q, state_d;
    logic [5:0]    pend_q, pend_d;
    logic [5:0]    active_q, active_d;
    logic [5:0]    cfg_bits_q, cfg_bits_d;
    logic          busy_q, busy_d;
    logic          rx_valid_q, rx_error_q;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          data_valid_q, data_valid_d;
    logic          ovf_q, ovf_d;
    logic [7:0]    err_q, err_d;
    logic [8:0]    mem_q [DEPTH];

    logic [3:0]    req_ws;
    logic          store;
    logic          push, pop, full, wr_en, ovf_ev, err_edge;
    logic [9:0]    mask10;
    logic [8:0]    wdata;

    always_comb begin
        if (i_cfg_word_size < 4'd5) begin
            req_ws = 4'd5;
        end else if (i_cfg_word_size > 4'd9) begin
            req_ws = 4'd9;
        end else begin
            req_ws = i_cfg_word_size;
        end

        // Strobe only while the receiver is idle and the line is high,
        // so the format never changes mid-frame.
        store    = (state_q == CFG_PEND) & i_rx_ready & i_rx_line;
        state_d  = state_q;
        pend_d   = pend_q;
        active_d = active_q;
        if (store) begin
            active_d = pend_q;
            state_d  = RUN;
        end
        // A new request always wins and keeps the FSM pending.
        if (i_cfg_apply) begin
            pend_d  = {i_cfg_two_stop, i_cfg_parity_en, req_ws};
            state_d = CFG_PEND;
        end
        busy_d     = (state_d == CFG_PEND);
        cfg_bits_d = busy_d ? pend_d : active_d;
    end

    always_comb begin
        push     = i_rx_valid & ~rx_valid_q;
        err_edge = i_rx_error & ~rx_error_q;
        full     = (count_q == FULL_CNT);
        pop      = data_valid_q & host.i_data_ready & ~i_flush;
        // A pop frees the slot the simultaneous push lands in.
        wr_en    = push & ~i_flush & (~full | pop);
        ovf_ev   = push & ~i_flush & full & ~pop;
        mask10   = (10'd1 << active_q[3:0]) - 10'd1;
        wdata    = i_rx_parallel & mask10[8:0];

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (wr_en && !pop) begin
                count_d = count_q + (AW+1)'(1);
            end else if (!wr_en && pop) begin
                count_d = count_q - (AW+1)'(1);
            end
        end
        data_valid_d = (count_d != '0);

        // Events win over a coincident clear.
        ovf_d = ovf_ev | (ovf_q & ~i_clear_status);
        err_d = err_q;
        if (i_clear_status) begin
            err_d = {7'd0, err_edge};
        end else if (err_edge && err_q != 8'hFF) begin
            err_d = err_q + 8'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= RUN;
            pend_q       <= CFG_RST;
            active_q     <= CFG_RST;
            cfg_bits_q   <= '0;
            busy_q       <= 1'b0;
            rx_valid_q   <= 1'b0;
            rx_error_q   <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            data_valid_q <= 1'b0;
            ovf_q        <= 1'b0;
            err_q        <= '0;
        end else begin
            state_q      <= state_d;
            pend_q       <= pend_d;
            active_q     <= active_d;
            cfg_bits_q   <= cfg_bits_d;
            busy_q       <= busy_d;
            rx_valid_q   <= i_rx_valid;
            rx_error_q   <= i_rx_error;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            data_valid_q <= data_valid_d;
            ovf_q        <= ovf_d;
            err_q        <= err_d;
        end
    end

    // Storage needs no reset; validity comes from the count.
    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign o_cfg_busy        = busy_q;
    assign o_cfg_active      = active_q;
    assign o_rx_config       = {cfg_bits_q, store};
    assign host.o_data       = mem_q[rd_ptr_q];
    assign host.o_data_valid = data_valid_q;
    assign o_fifo_count      = count_q;
    assign o_overflow        = ovf_q;
    assign o_err_count       = err_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: directed steps plus random
// traffic against a queue-based reference model.
module tb_uart_rx_ctrl;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [3:0]    cfg_ws;
    logic          cfg_par, cfg_two, cfg_apply;
    logic          busy;
    logic [5:0]    active;
    logic [6:0]    rx_config;
    logic [8:0]    rx_par;
    logic          rx_valid, rx_ready, rx_error, rx_line;
    logic [AW:0]   fcount;
    logic          ovf;
    logic [7:0]    errc;
    logic          clr, flush;

    uart_rx_ctrl_if host_if ();

    always #5 clk = ~clk;

    uart_rx_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_cfg_word_size (cfg_ws),
        .i_cfg_parity_en (cfg_par),
        .i_cfg_two_stop  (cfg_two),
        .i_cfg_apply     (cfg_apply),
        .o_cfg_busy      (busy),
        .o_cfg_active    (active),
        .o_rx_config     (rx_config),
        .i_rx_parallel   (rx_par),
        .i_rx_valid      (rx_valid),
        .i_rx_ready      (rx_ready),
        .i_rx_error      (rx_error),
        .i_rx_line       (rx_line),
        .host            (host_if),
        .o_fifo_count    (fcount),
        .o_overflow      (ovf),
        .o_err_count     (errc),
        .i_clear_status  (clr),
        .i_flush         (flush)
    );

    int         checks = 0;
    int         failures = 0;
    int         q[$];
    int         m_ovf, m_err;
    logic [5:0] m_active, m_pend;
    bit         m_busy, m_pv, m_pe;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int clamp_ws(int ws);
        if (ws < 5) return 5;
        if (ws > 9) return 9;
        return ws;
    endfunction

    task automatic model_reset();
        q.delete();
        m_ovf    = 0;
        m_err    = 0;
        m_active = 6'h08;
        m_pend   = 6'h08;
        m_busy   = 0;
        m_pv     = 0;
        m_pe     = 0;
    endtask

    task automatic check_all();
        logic [6:0] exp_cfg;
        chk("valid", host_if.o_data_valid, q.size() != 0);
        chk("count", fcount, q.size());
        if (q.size() != 0) chk("data", host_if.o_data, q[0]);
        chk("ovf", ovf, m_ovf);
        chk("errc", errc, m_err);
        chk("busy", busy, m_busy);
        chk("active", active, m_active);
        if (m_busy) exp_cfg = {m_pend, 1'(rx_ready & rx_line)};
        else        exp_cfg = {m_active, 1'b0};
        chk("rxcfg", rx_config, exp_cfg);
    endtask

    // Advance the model over the coming edge, clock, then compare.
    task automatic tick();
        bit push, pop, eedge, strobe, ev;
        int ws;
        push   = rx_valid && !m_pv;
        eedge  = rx_error && !m_pe;
        strobe = m_busy && rx_ready && rx_line;
        pop    = (q.size() != 0) && host_if.i_data_ready;
        ws     = int'(m_active[3:0]);
        ev     = 0;
        if (flush) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (push) begin
                if (q.size() < DEPTH) q.push_back(int'(rx_par) & ((1 << ws) - 1));
                else ev = 1;
            end
        end
        m_ovf = ev ? 1 : (clr ? 0 : m_ovf);
        if (clr) m_err = eedge ? 1 : 0;
        else if (eedge && m_err < 255) m_err++;
        if (strobe) begin
            m_active = m_pend;
            m_busy   = 0;
        end
        if (cfg_apply) begin
            m_pend = {cfg_two, cfg_par, 4'(clamp_ws(int'(cfg_ws)))};
            m_busy = 1;
        end
        m_pv = rx_valid;
        m_pe = rx_error;
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic push_word(logic [8:0] w);
        rx_par   = w;
        rx_valid = 1;
        tick();
        rx_valid = 0;
        tick();
    endtask

    task automatic drain();
        host_if.i_data_ready = 1;
        for (int i = 0; i < 2 * DEPTH && q.size() != 0; i++) tick();
        host_if.i_data_ready = 0;
        chk("drained", fcount, 0);
    endtask

    task automatic apply_cfg(logic [3:0] ws, logic par, logic two);
        cfg_ws    = ws;
        cfg_par   = par;
        cfg_two   = two;
        cfg_apply = 1;
        tick();
        cfg_apply = 0;
    endtask

    initial begin
        rst_n = 0; cfg_ws = 0; cfg_par = 0; cfg_two = 0; cfg_apply = 0;
        rx_par = 0; rx_valid = 0; rx_ready = 1; rx_error = 0; rx_line = 1;
        clr = 0; flush = 0; host_if.i_data_ready = 0;
        model_reset();

        #12;
        chk("rst_valid", host_if.o_data_valid, 0);
        chk("rst_count", fcount, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_err", errc, 0);
        chk("rst_busy", busy, 0);
        chk("rst_active", active, 6'h08);
        chk("rst_rxcfg", rx_config, 0);
        @(negedge clk);
        rst_n = 1;
        tick();

        // Three words at word size 8; bit 8 is masked off.
        push_word(9'h041);
        push_word(9'h0A5);
        push_word(9'h1FF);
        chk("three_count", fcount, 3);
        chk("head0", host_if.o_data, 9'h041);
        host_if.i_data_ready = 1;
        tick();
        chk("head1", host_if.o_data, 9'h0A5);
        tick();
        chk("head2", host_if.o_data, 9'h0FF);
        tick();
        host_if.i_data_ready = 0;
        chk("empty", host_if.o_data_valid, 0);

        // Config held off while the line is low.
        rx_line = 0;
        rx_ready = 1;
        apply_cfg(4'd3, 1, 1);
        for (int i = 0; i < 10; i++) tick();
        chk("pend_busy", busy, 1);
        chk("no_strobe", rx_config[0], 0);
        rx_line = 1;
        #1;
        chk("strobe", rx_config, 7'b1101011);
        tick();
        chk("cfg_applied", active, 6'b110101);
        chk("cfg_idle", busy, 0);
        apply_cfg(4'd8, 0, 0);
        tick();
        chk("cfg_back8", active, 6'h08);

        // Fill, overflow, then push+pop at full.
        for (int i = 0; i < DEPTH; i++) push_word(9'($urandom));
        chk("full_count", fcount, DEPTH);
        push_word(9'($urandom));
        chk("ovf_set", ovf, 1);
        chk("ovf_count", fcount, DEPTH);
        rx_par = 9'($urandom);
        rx_valid = 1;
        host_if.i_data_ready = 1;
        tick();
        rx_valid = 0;
        host_if.i_data_ready = 0;
        tick();
        chk("pushpop_count", fcount, DEPTH);
        drain();
        clr = 1;
        tick();
        clr = 0;
        chk("ovf_clr", ovf, 0);

        // Error statistics saturate, clear with coincident edge.
        for (int i = 0; i < 260; i++) begin
            rx_error = 1;
            tick();
            rx_error = 0;
            tick();
        end
        chk("err_sat", errc, 255);
        clr = 1;
        rx_error = 1;
        tick();
        clr = 0;
        rx_error = 0;
        tick();
        chk("err_clr_edge", errc, 1);

        // Held valid pushes once.
        rx_par = 9'h055;
        rx_valid = 1;
        for (int i = 0; i < 5; i++) tick();
        rx_valid = 0;
        tick();
        chk("hold_one", fcount, 1);

        // Flush discards a coincident push.
        push_word(9'h011);
        push_word(9'h022);
        rx_valid = 1;
        flush = 1;
        tick();
        rx_valid = 0;
        flush = 0;
        tick();
        chk("flush_count", fcount, 0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            rx_valid = ($urandom % 3) == 0;
            rx_par = 9'($urandom);
            host_if.i_data_ready = ($urandom % 2) == 0;
            rx_error = ($urandom % 4) == 0;
            clr = ($urandom % 25) == 0;
            flush = ($urandom % 40) == 0;
            cfg_apply = ($urandom % 15) == 0;
            cfg_ws = 4'($urandom);
            cfg_par = 1'($urandom);
            cfg_two = 1'($urandom);
            rx_line = ($urandom % 3) != 0;
            rx_ready = ($urandom % 2) == 0;
            tick();
        end
        rx_valid = 0; rx_error = 0; clr = 0; flush = 0; cfg_apply = 0;
        host_if.i_data_ready = 0;
        tick();

        // Async reset while pending with words queued.
        drain();
        rx_line = 0;
        apply_cfg(4'd6, 1, 0);
        for (int i = 0; i < 4; i++) push_word(9'($urandom));
        chk("pre_rst_count", fcount, 4);
        chk("pre_rst_busy", busy, 1);
        #2;
        rst_n = 0;
        #1;
        chk("arst_valid", host_if.o_data_valid, 0);
        chk("arst_count", fcount, 0);
        chk("arst_busy", busy, 0);
        chk("arst_active", active, 6'h08);
        chk("arst_rxcfg", rx_config, 0);
        model_reset();
        rx_line = 1;
        @(negedge clk);
        rst_n = 1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
